// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - multi-cycle ripple-borrow subtractor, one DIGIT-bit slice per clock
// Computes S = A - B - Bin LSB slice first, with start/busy/done handshake and ovf/zero flags.
module subtrator_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] S,
  output logic             Bo,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [CW-1:0]    k_q, k_d;
  logic             borrow_q, borrow_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bo_q, bo_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT:0]   slice_diff;
  logic [WIDTH-1:0] slice_ext;
  logic             accept;

  // Operands shift right so the active slice is always in the low DIGIT bits;
  // sign bits are kept aside because the shifted copies lose them.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    k_d        = k_q;
    borrow_d   = borrow_q;
    amsb_d     = amsb_q;
    bmsb_d     = bmsb_q;
    s_d        = s_q;
    bo_d       = bo_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    accept     = 1'b0;
    slice_diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    slice_ext  = WIDTH'(slice_diff[DIGIT-1:0]);

    case (state_q)
      IDLE: accept = start;
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = (res_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
        borrow_d = slice_diff[DIGIT];
        k_d      = k_q + 1'b1;
        if (k_q == LAST) begin
          state_d = DONE;
          k_d     = '0;
          s_d     = res_d;
          bo_d    = slice_diff[DIGIT];
          ovf_d   = (amsb_q ^ bmsb_q) & (res_d[WIDTH-1] ^ amsb_q);
          zero_d  = ~|res_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = RUN;
      a_d      = A;
      b_d      = B;
      borrow_d = Bin;
      k_d      = '0;
      amsb_d   = A[WIDTH-1];
      bmsb_d   = B[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      k_q      <= '0;
      borrow_q <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      s_q      <= '0;
      bo_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      k_q      <= k_d;
      borrow_q <= borrow_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      s_q      <= s_d;
      bo_q     <= bo_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign S    = s_q;
  assign Bo   = bo_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
